// File: rtl/pc_sequencer.sv
// Program-counter sequencer: reset-release hold, stall, redirect, address limit with wrap.
// Optional out-of-range redirect trap enabled by defining PC_TRAP_EN.
module pc_sequencer #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      STEP        = 4,
  parameter logic [WIDTH-1:0] MAX_ADDR    = 252,
  parameter logic [WIDTH-1:0] RESET_ADDR  = 0,
  parameter int unsigned      HOLD_CYCLES = 1
`ifdef PC_TRAP_EN
  ,
  parameter logic [WIDTH-1:0] TRAP_VECTOR = 0
`endif
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             Redirect,
  input  logic [WIDTH-1:0] Target,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCPlus,
  output logic             Valid,
  output logic             Wrapped
`ifdef PC_TRAP_EN
  ,
  output logic             Trap
`endif
);

  localparam logic [WIDTH:0] STEP_EXT  = (WIDTH+1)'(STEP);
  localparam logic [3:0]     HOLD_INIT = 4'(HOLD_CYCLES);

  typedef enum logic {ST_HOLD, ST_RUN} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       hold_cnt_reg, hold_cnt_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic             valid_reg;
  logic             wrapped_reg, wrapped_next;
  logic [WIDTH:0]   seq_sum;
  logic [WIDTH:0]   nxt;
  logic             out_of_range;
`ifdef PC_TRAP_EN
  logic             trap_reg, trap_next;
`endif

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg    <= ST_HOLD;
      hold_cnt_reg <= HOLD_INIT;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  // Next-state logic: HOLD counts down to zero, then RUN until reset
  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    case (state_reg)
      ST_HOLD: begin
        if (hold_cnt_reg == 4'd0) begin
          state_next = ST_RUN;
        end else begin
          hold_cnt_next = hold_cnt_reg - 4'd1;
        end
      end
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_HOLD;
    endcase
  end

  // Candidate address on WIDTH+1 bits so the carry-out counts as out of range
  always_comb begin
    seq_sum      = {1'b0, pc_reg} + STEP_EXT;
    nxt          = Redirect ? {1'b0, Target} : seq_sum;
    out_of_range = nxt[WIDTH] || (nxt[WIDTH-1:0] > MAX_ADDR);
  end

  // Output logic: next PC and the one-cycle status pulses
  always_comb begin
    pc_next      = pc_reg;
    wrapped_next = 1'b0;
`ifdef PC_TRAP_EN
    trap_next    = 1'b0;
`endif
    case (state_reg)
      ST_HOLD: pc_next = RESET_ADDR;
      ST_RUN: begin
        // Redirect beats Stall; a stalled cycle skips the limit check entirely
        if (Redirect || !Stall) begin
          if (!out_of_range) begin
            pc_next = nxt[WIDTH-1:0];
          end else begin
`ifdef PC_TRAP_EN
            if (Redirect) begin
              pc_next   = TRAP_VECTOR;
              trap_next = 1'b1;
            end else begin
              pc_next      = RESET_ADDR;
              wrapped_next = 1'b1;
            end
`else
            pc_next      = RESET_ADDR;
            wrapped_next = 1'b1;
`endif
          end
        end
      end
      default: pc_next = RESET_ADDR;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc_reg      <= RESET_ADDR;
      valid_reg   <= 1'b0;
      wrapped_reg <= 1'b0;
`ifdef PC_TRAP_EN
      trap_reg    <= 1'b0;
`endif
    end else begin
      pc_reg      <= pc_next;
      valid_reg   <= (state_next == ST_RUN);
      wrapped_reg <= wrapped_next;
`ifdef PC_TRAP_EN
      trap_reg    <= trap_next;
`endif
    end
  end

  assign PC      = pc_reg;
  assign PCPlus  = seq_sum[WIDTH-1:0];
  assign Valid   = valid_reg;
  assign Wrapped = wrapped_reg;
`ifdef PC_TRAP_EN
  assign Trap    = trap_reg;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios, random stall/redirect, async reset.
module tb_pc_sequencer;

  localparam logic [31:0] MAX_A = 32'd252;
  localparam logic [31:0] TRAP_V = 32'd200;

  logic        Clock;
  logic        Reset;
  logic        Stall;
  logic        Redirect;
  logic [31:0] Target;
  logic [31:0] PC;
  logic [31:0] PCPlus;
  logic        Valid;
  logic        Wrapped;
`ifdef PC_TRAP_EN
  logic        Trap;
`endif

`ifdef PC_TRAP_EN
  pc_sequencer #(
    .WIDTH(32), .STEP(4), .MAX_ADDR(MAX_A), .RESET_ADDR(32'd0),
    .HOLD_CYCLES(1), .TRAP_VECTOR(TRAP_V)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .Redirect(Redirect),
    .Target(Target), .PC(PC), .PCPlus(PCPlus), .Valid(Valid),
    .Wrapped(Wrapped), .Trap(Trap)
  );
`else
  pc_sequencer #(
    .WIDTH(32), .STEP(4), .MAX_ADDR(MAX_A), .RESET_ADDR(32'd0),
    .HOLD_CYCLES(1)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .Redirect(Redirect),
    .Target(Target), .PC(PC), .PCPlus(PCPlus), .Valid(Valid),
    .Wrapped(Wrapped)
  );
`endif

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        wrapped;
    logic        trap;
  } exp_t;

  exp_t        sb_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;

  // Reference model state
  bit          m_run;
  int          m_cnt;
  logic [31:0] m_pc;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_cnt = 1;
    m_pc  = 32'd0;
  endtask

  // Advance the model by one clock and queue the expected post-edge outputs
  task automatic model_push(input logic st, input logic rd, input logic [31:0] tg);
    exp_t   e;
    longint n;
    e.wrapped = 1'b0;
    e.trap    = 1'b0;
    if (!m_run) begin
      if (m_cnt == 0) m_run = 1'b1;
      else m_cnt = m_cnt - 1;
      m_pc = 32'd0;
    end else if (rd) begin
      if (tg > MAX_A) begin
`ifdef PC_TRAP_EN
        m_pc   = TRAP_V;
        e.trap = 1'b1;
`else
        m_pc      = 32'd0;
        e.wrapped = 1'b1;
`endif
      end else begin
        m_pc = tg;
      end
    end else if (!st) begin
      n = longint'(m_pc) + 4;
      if (n > longint'(MAX_A)) begin
        m_pc      = 32'd0;
        e.wrapped = 1'b1;
      end else begin
        m_pc = 32'(n);
      end
    end
    e.pc    = m_pc;
    e.valid = m_run;
    sb_q.push_back(e);
  endtask

  task automatic step(input logic st, input logic rd, input logic [31:0] tg);
    exp_t e;
    check("pcplus", PCPlus, m_pc + 32'd4);
    Stall    = st;
    Redirect = rd;
    Target   = tg;
    model_push(st, rd, tg);
    @(posedge Clock);
    #1;
    cyc++;
    e = sb_q.pop_front();
    check("pc", PC, e.pc);
    check("valid", 32'(Valid), 32'(e.valid));
    check("wrapped", 32'(Wrapped), 32'(e.wrapped));
`ifdef PC_TRAP_EN
    check("trap", 32'(Trap), 32'(e.trap));
`endif
    $display("[TB] cyc %0d stall=%0b redir=%0b tgt=%0d -> pc=%0d valid=%0b wrapped=%0b",
             cyc, st, rd, tg, PC, Valid, Wrapped);
  endtask

  initial begin
    Reset    = 1'b1;
    Stall    = 1'b0;
    Redirect = 1'b0;
    Target   = 32'd0;
    model_reset();
    repeat (2) @(posedge Clock);
    #1;
    check("rst_pc", PC, 32'd0);
    check("rst_valid", 32'(Valid), 32'd0);
    check("rst_wrapped", 32'(Wrapped), 32'd0);
    Reset = 1'b0;

    // Hold release then sequential fetch
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check("seq_pc8", PC, 32'd8);

    // Stall at PC=8 for three cycles
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    check("stall_pcplus", PCPlus, 32'd12);
    step(0, 0, 0);
    check("after_stall_pc", PC, 32'd12);
    step(0, 0, 0);

    // Redirect overrides Stall
    step(1, 1, 32'd100);
    check("redir_over_stall", PC, 32'd100);

    // Sequential limit: 248 -> 252 -> wrap to 0
    step(0, 1, 32'd248);
    step(0, 0, 0);
    check("max_pc", PC, 32'd252);
    check("max_no_wrap", 32'(Wrapped), 32'd0);
    step(0, 0, 0);
    check("wrap_pc", PC, 32'd0);
    check("wrap_pulse", 32'(Wrapped), 32'd1);
    step(0, 0, 0);
    check("wrap_one_cycle", 32'(Wrapped), 32'd0);

    // Stall held at MAX_ADDR does not wrap
    step(0, 1, 32'd252);
    step(1, 0, 0);
    step(1, 0, 0);
    check("stall_at_max", PC, 32'd252);
    step(0, 0, 0);

    // Out-of-range redirect
    step(0, 1, 32'd300);
`ifdef PC_TRAP_EN
    check("trap_pc", PC, 32'd200);
`else
    check("oor_redir_pc", PC, 32'd0);
`endif

    // Misaligned target loaded as-is
    step(0, 1, 32'd101);
    step(0, 0, 0);
    check("misaligned_seq", PC, 32'd105);

    // Random stall/redirect traffic
    for (int i = 0; i < 150; i++) begin
      logic        st, rd;
      logic [31:0] tg;
      st = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 7) == 0);
      tg = 32'($urandom_range(0, 320));
      if ($urandom_range(0, 1) == 1) tg = tg & ~32'd3;
      step(st, rd, tg);
    end

    // Asynchronous reset mid-run at PC=40
    step(0, 1, 32'd40);
    check("pre_reset_pc", PC, 32'd40);
    #2;
    Reset = 1'b1;
    #1;
    check("async_rst_pc", PC, 32'd0);
    check("async_rst_valid", 32'(Valid), 32'd0);
    model_reset();
    @(posedge Clock);
    #1;
    Reset = 1'b0;

    // Redirects during hold are dropped
    step(0, 1, 32'd100);
    step(0, 1, 32'd100);
    check("hold_redir_ignored", PC, 32'd0);
    step(0, 0, 0);
    check("post_hold_seq", PC, 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
